// File: rtl/turn_ctrl.sv
// Turn sequencer for check_win: debounces the button, validates the card, strobes B, advances the player.
// Optional per-turn idle timeout is built only when TURN_TIMEOUT_EN is defined.
module turn_ctrl #(
    parameter int NUM_PLAYERS    = 4,
    parameter int DB_CYCLES      = 250000,
    parameter int DB_W           = 18,
    parameter int MAX_CARD       = 23,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [4:0] sel_card,
    input  logic       match,
    input  logic       W,
    output logic [1:0] T,
    output logic [4:0] N,
    output logic       B,
    output logic       game_over,
    output logic       reject,
    output logic       timeout
);

    typedef enum logic [2:0] {
        WAIT_PRESS,
        DEBOUNCE,
        ISSUE,
        EVAL,
        WAIT_RELEASE,
        GAME_OVER
    } state_t;

    state_t          state;
    logic            sync1;
    logic            btn_s;
    logic [DB_W-1:0] db_cnt;

    function automatic logic [1:0] next_player(input logic [1:0] p);
        return (p == 2'(NUM_PLAYERS - 1)) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef TURN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_fire;

    assign to_fire = ((state == WAIT_PRESS) || (state == DEBOUNCE)) &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_PRESS;
            sync1     <= 1'b0;
            btn_s     <= 1'b0;
            db_cnt    <= '0;
            T         <= '0;
            N         <= '0;
            B         <= 1'b0;
            game_over <= 1'b0;
            reject    <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            timeout   <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            sync1  <= btn_raw;
            btn_s  <= sync1;
            B      <= 1'b0;
            reject <= 1'b0;

            case (state)
                WAIT_PRESS: begin
                    if (btn_s) begin
                        db_cnt <= '0;
                        state  <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s) begin
                        db_cnt <= '0;
                        state  <= WAIT_PRESS;
                    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                        if (sel_card <= 5'(MAX_CARD)) begin
                            N     <= sel_card;
                            B     <= 1'b1;
                            state <= ISSUE;
                        end else begin
                            reject <= 1'b1;
                            state  <= WAIT_RELEASE;
                        end
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                ISSUE: state <= EVAL;
                EVAL: begin
                    if (W) begin
                        game_over <= 1'b1;
                        state     <= GAME_OVER;
                    end else begin
                        if (!match) T <= next_player(T);
                        state <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!btn_s) state <= WAIT_PRESS;
                end
                GAME_OVER: state <= GAME_OVER;
                default:   state <= WAIT_PRESS;
            endcase

`ifdef TURN_TIMEOUT_EN
            // Counter idles at zero outside WAIT_PRESS/DEBOUNCE, which covers the B, reject and T-change clears.
            timeout <= 1'b0;
            if ((state == WAIT_PRESS) || (state == DEBOUNCE)) to_cnt <= to_cnt + 1'b1;
            else to_cnt <= '0;

            // Timeout overrides whatever the FSM decided this cycle, including a same-cycle accept.
            if (to_fire) begin
                timeout <= 1'b1;
                T       <= next_player(T);
                N       <= N;
                B       <= 1'b0;
                reject  <= 1'b0;
                db_cnt  <= '0;
                to_cnt  <= '0;
                state   <= WAIT_PRESS;
            end
`endif
        end
    end

endmodule

// File: tb/tb_turn_ctrl.sv
// Directed bench for turn_ctrl with short debounce; press vectors in a table plus hand sequences.
// Define TURN_TIMEOUT_EN to exercise the idle-timeout path instead of the press table.
module tb_turn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic [4:0] sel_card = '0;
    logic       match = 1'b0;
    logic       W = 1'b0;
    logic [1:0] T;
    logic [4:0] N;
    logic       B;
    logic       game_over;
    logic       reject;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    int mon_b = 0;
    int mon_rej = 0;
    int mon_to = 0;

    turn_ctrl #(
        .NUM_PLAYERS   (4),
        .DB_CYCLES     (4),
        .DB_W          (3),
        .MAX_CARD      (23),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .sel_card (sel_card),
        .match    (match),
        .W        (W),
        .T        (T),
        .N        (N),
        .B        (B),
        .game_over(game_over),
        .reject   (reject),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (B) mon_b++;
        if (reject) mon_rej++;
        if (timeout) mon_to++;
        if (B || reject || timeout)
            check("pulse_exclusive", int'(B) + int'(reject) + int'(timeout), 1);
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        btn_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_T"}, int'(T), 0);
        check({tag, "_N"}, int'(N), 0);
        check({tag, "_B"}, int'(B), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
        check({tag, "_reject"}, int'(reject), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
    endtask

`ifndef TURN_TIMEOUT_EN
    typedef struct {
        logic [4:0] sel;
        logic       m;
        logic       w;
        int         hold;
        int         exp_b;
        int         exp_rej;
        int         exp_n;
        int         exp_t;
        int         exp_go;
    } vec_t;

    vec_t vecs[14];
`endif

    initial begin
        int lat;
        do_reset();
        check_reset_outputs("reset");

`ifdef TURN_TIMEOUT_EN
        // Valid press with match=0 moves to T=1.
        @(posedge clk); #1;
        sel_card = 5'd7; match = 1'b0; W = 1'b0; btn_raw = 1'b1;
        repeat (8) @(posedge clk);
        #1 btn_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("to_press_T", int'(T), 1);
        check("to_press_N", int'(N), 7);
        mon_b = 0; mon_to = 0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (timeout) begin
                lat = i;
                break;
            end
        end
        check("to_seen", int'(lat != 0), 1);
        check("to_T_adv", int'(T), 2);
        check("to_N_kept", int'(N), 7);
        repeat (11) @(posedge clk);
        #1;
        check("to_second_T", int'(T), 3);
        check("to_count", mon_to, 2);
        repeat (10) @(posedge clk);
        #1;
        check("to_wrap_T", int'(T), 0);
        check("to_no_B", mon_b, 0);
`else
        // Latency: B is high in the 7th clock after btn_raw is first sampled.
        @(posedge clk); #1;
        sel_card = 5'd7; match = 1'b0; W = 1'b0; btn_raw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (B) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 7);
        check("lat_N", int'(N), 7);
        @(posedge clk); #1;
        check("b_one_cycle", int'(B), 0);
        @(posedge clk); #1;
        check("t_after_b", int'(T), 1);
        btn_raw = 1'b0;
        repeat (10) @(posedge clk);

        // Reset during DEBOUNCE aborts the press.
        #1 mon_b = 0;
        sel_card = 5'd8; btn_raw = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; btn_raw = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rst_mid_db_B", mon_b, 0);
        check("rst_mid_db_T", int'(T), 0);
        check("rst_mid_db_N", int'(N), 0);

        // Reset sampled on the edge that would enter ISSUE: no B.
        mon_b = 0;
        btn_raw = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1; btn_raw = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rst_at_issue_B", mon_b, 0);
        check("rst_at_issue_N", int'(N), 0);

        //             sel    m     w     hold b rej  N   T go
        vecs[0]  = '{5'd7,  1'b0, 1'b0, 12, 1, 0,  7, 1, 0};
        vecs[1]  = '{5'd9,  1'b0, 1'b0,  3, 0, 0,  7, 1, 0};
        vecs[2]  = '{5'd9,  1'b0, 1'b0,  4, 0, 0,  7, 1, 0};
        vecs[3]  = '{5'd9,  1'b1, 1'b0,  5, 1, 0,  9, 1, 0};
        vecs[4]  = '{5'd23, 1'b0, 1'b0,  8, 1, 0, 23, 2, 0};
        vecs[5]  = '{5'd0,  1'b0, 1'b0, 20, 1, 0,  0, 3, 0};
        vecs[6]  = '{5'd12, 1'b0, 1'b0, 20, 1, 0, 12, 0, 0};
        vecs[7]  = '{5'd25, 1'b0, 1'b0, 10, 0, 1, 12, 0, 0};
        vecs[8]  = '{5'd24, 1'b0, 1'b0, 10, 0, 1, 12, 0, 0};
        vecs[9]  = '{5'd31, 1'b1, 1'b0, 10, 0, 1, 12, 0, 0};
        vecs[10] = '{5'd5,  1'b0, 1'b0, 10, 1, 0,  5, 1, 0};
        vecs[11] = '{5'd6,  1'b0, 1'b0, 10, 1, 0,  6, 2, 0};
        vecs[12] = '{5'd3,  1'b1, 1'b1, 10, 1, 0,  3, 2, 1};
        vecs[13] = '{5'd4,  1'b0, 1'b0, 10, 0, 0,  3, 2, 1};

        for (int v = 0; v < 14; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            @(posedge clk); #1;
            mon_b = 0; mon_rej = 0;
            sel_card = vecs[v].sel; match = vecs[v].m; W = vecs[v].w;
            btn_raw = 1'b1;
            repeat (vecs[v].hold) @(posedge clk);
            #1 btn_raw = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            check({tag, "_B"}, mon_b, vecs[v].exp_b);
            check({tag, "_reject"}, mon_rej, vecs[v].exp_rej);
            check({tag, "_N"}, int'(N), vecs[v].exp_n);
            check({tag, "_T"}, int'(T), vecs[v].exp_t);
            check({tag, "_game_over"}, int'(game_over), vecs[v].exp_go);
        end

        match = 1'b0; W = 1'b0;
        do_reset();
        check_reset_outputs("post_win_reset");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
